// File: rtl/reg_phase_sequencer_pkg.sv
// reg_phase_sequencer_pkg: shared REG_SEQX codes, byte-access codes and one-hot phase encodings.
package reg_phase_sequencer_pkg;
  localparam logic [2:0] REG_SEQX_NONE    = 3'd0;
  localparam logic [2:0] REG_SEQX_RDA_RDB = 3'd1;
  localparam logic [2:0] REG_SEQX_LDA_RDB = 3'd2;
  localparam logic [2:0] REG_SEQX_LDA_UPB = 3'd3;
  localparam logic [2:0] REG_SEQX_RDA_UPB = 3'd4;
  localparam logic [2:0] REG_SEQX_LDA_IMM = 3'd5;
  localparam logic BYTEX_WORD = 1'b0;
  localparam logic BYTEX_BYTE = 1'b1;
  // One-hot so each phase strobe is a single state-register bit.
  typedef enum logic [3:0] {
    PH_IDLE    = 4'b0000,
    PH_FETCH   = 4'b0001,
    PH_DECODE  = 4'b0010,
    PH_EXECUTE = 4'b0100,
    PH_COMMIT  = 4'b1000
  } phase_e;
endpackage

// File: rtl/reg_phase_sequencer_instruction_phase_decoder.sv
// instruction_phase_decoder: free-running FETCH/DECODE/EXECUTE/COMMIT ring and instruction latch.
module instruction_phase_decoder
  import reg_phase_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  PC_ENX,
  output phase_e                phase,
  output logic [DATA_WIDTH-1:0] INSTRUCTION
);
  phase_e state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  always_comb begin
    state_d = (state_q == PH_FETCH)   ? PH_DECODE  :
              (state_q == PH_DECODE)  ? PH_EXECUTE :
              (state_q == PH_EXECUTE) ? PH_COMMIT  : PH_FETCH;
    instr_d = (state_q == PH_FETCH && PC_ENX) ? DIN : instr_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= PH_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end
  assign phase       = state_q;
  assign INSTRUCTION = instr_q;
endmodule

// File: rtl/reg_phase_sequencer.sv
// reg_phase_sequencer: phase ring plus REG_SEQX register-port enable decode; REG_BYTE_LANE_EN adds REGA_WBE.
module reg_phase_sequencer
  import reg_phase_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  PC_ENX,
  input  logic [2:0]            REG_SEQX,
  input  logic                  BYTEX,
  input  logic                  A0,
  output logic                  FETCH,
  output logic                  DECODE,
  output logic                  EXECUTE,
  output logic                  COMMIT,
  output logic [DATA_WIDTH-1:0] INSTRUCTION,
  output logic                  REGA_EN,
  output logic                  REGA_WEN,
  output logic                  REGB_EN,
`ifdef REG_BYTE_LANE_EN
  output logic                  REGB_WEN,
  output logic [1:0]            REGA_WBE
`else
  output logic                  REGB_WEN
`endif
);
  phase_e phase;
  logic   active;
  instruction_phase_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_ipd (
    .CLK         (CLK),
    .RESET       (RESET),
    .DIN         (DIN),
    .PC_ENX      (PC_ENX),
    .phase       (phase),
    .INSTRUCTION (INSTRUCTION)
  );
  assign FETCH   = phase[0];
  assign DECODE  = phase[1];
  assign EXECUTE = phase[2];
  assign COMMIT  = phase[3];
  assign active  = DECODE | EXECUTE | COMMIT;
  always_comb begin
    REGA_EN  = active && (REG_SEQX inside {REG_SEQX_RDA_RDB, REG_SEQX_LDA_RDB, REG_SEQX_LDA_UPB,
                                           REG_SEQX_RDA_UPB, REG_SEQX_LDA_IMM});
    REGB_EN  = active && (REG_SEQX inside {REG_SEQX_RDA_RDB, REG_SEQX_LDA_RDB, REG_SEQX_LDA_UPB,
                                           REG_SEQX_RDA_UPB});
    REGA_WEN = COMMIT && (REG_SEQX inside {REG_SEQX_LDA_RDB, REG_SEQX_LDA_UPB, REG_SEQX_LDA_IMM});
    REGB_WEN = COMMIT && (REG_SEQX inside {REG_SEQX_LDA_UPB, REG_SEQX_RDA_UPB});
  end
`ifdef REG_BYTE_LANE_EN
  assign REGA_WBE = (BYTEX == BYTEX_WORD) ? {2{REGA_WEN}} :
                    A0 ? {REGA_WEN, 1'b0} : {1'b0, REGA_WEN};
`else
  logic unused_byte_lane;
  assign unused_byte_lane = ^{BYTEX, A0};
`endif
endmodule

// File: tb/tb_reg_phase_sequencer.sv
// tb_reg_phase_sequencer: randomized and directed checks against a phase-counter reference model.
module tb_reg_phase_sequencer;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] DIN = '0;
  logic        PC_ENX = 1'b0;
  logic [2:0]  REG_SEQX = '0;
  logic        BYTEX = 1'b0;
  logic        A0 = 1'b0;
  logic        FETCH, DECODE, EXECUTE, COMMIT;
  logic [15:0] INSTRUCTION;
  logic        REGA_EN, REGA_WEN, REGB_EN, REGB_WEN;
`ifdef REG_BYTE_LANE_EN
  logic [1:0]  REGA_WBE;
`endif
  reg_phase_sequencer #(.DATA_WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .DIN(DIN), .PC_ENX(PC_ENX), .REG_SEQX(REG_SEQX),
    .BYTEX(BYTEX), .A0(A0), .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE),
    .COMMIT(COMMIT), .INSTRUCTION(INSTRUCTION), .REGA_EN(REGA_EN), .REGA_WEN(REGA_WEN),
`ifdef REG_BYTE_LANE_EN
    .REGB_EN(REGB_EN), .REGB_WEN(REGB_WEN), .REGA_WBE(REGA_WBE)
`else
    .REGB_EN(REGB_EN), .REGB_WEN(REGB_WEN)
`endif
  );
  always #5 CLK = ~CLK;
  int checks = 0;
  int failures = 0;
  int ph = 0;
  logic [15:0] m_instr = '0;
  // Model phase: 0 idle, 1 fetch, 2 decode, 3 execute, 4 commit.
  function automatic logic [7:0] exp_vec(int p, logic [2:0] c);
    logic [3:0] strobes;
    bit reads_a, reads_b, loads_a, updates_b;
    strobes   = (p == 0) ? 4'b0000 : 4'b1000 >> (p - 1);
    reads_a   = (c >= 3'd1 && c <= 3'd5);
    reads_b   = (c >= 3'd1 && c <= 3'd4);
    loads_a   = (c == 3'd2 || c == 3'd3 || c == 3'd5);
    updates_b = (c == 3'd3 || c == 3'd4);
    return {strobes, reads_a && p >= 2, loads_a && p == 4, reads_b && p >= 2, updates_b && p == 4};
  endfunction
  function automatic logic [7:0] obs();
    return {FETCH, DECODE, EXECUTE, COMMIT, REGA_EN, REGA_WEN, REGB_EN, REGB_WEN};
  endfunction
`ifdef REG_BYTE_LANE_EN
  function automatic logic [1:0] exp_wbe(int p, logic [2:0] c, logic b, logic a);
    logic w;
    w = exp_vec(p, c)[2];
    return !b ? {w, w} : (a ? {w, 1'b0} : {1'b0, w});
  endfunction
`endif
  task automatic tick();
    bit r, pe;
    logic [15:0] d;
    int old;
    r = RESET; pe = PC_ENX; d = DIN; old = ph;
    @(posedge CLK);
    if (r) begin
      ph = 0; m_instr = '0;
    end else begin
      ph = (old == 0 || old == 4) ? 1 : old + 1;
      if (old == 1 && pe) m_instr = d;
    end
    #1;
  endtask
  task automatic test_reset();
    RESET = 1'b1; REG_SEQX = 3'd3;
    tick(); tick();
    checks++;
    if (obs() !== 8'h00) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", obs(), 8'h00); end
    checks++;
    if (INSTRUCTION !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=0000", INSTRUCTION); end
  endtask
  task automatic test_phase_ring();
    logic [3:0] seq_exp [4];
    seq_exp[0] = 4'b1000; seq_exp[1] = 4'b0100; seq_exp[2] = 4'b0010; seq_exp[3] = 4'b0001;
    RESET = 1'b0; REG_SEQX = 3'd0;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (obs()[7:4] !== seq_exp[i % 4]) begin
        failures++; $display("FAIL phase_ring[%0d] got=%b exp=%b", i, obs()[7:4], seq_exp[i % 4]);
      end
    end
  endtask
  task automatic test_instruction();
    for (int i = 0; i < 8 && ph != 1; i++) tick();
    checks++;
    if (!FETCH) begin failures++; $display("FAIL instr_wait_fetch got=%b exp=1", FETCH); end
    DIN = 16'hA55A; PC_ENX = 1'b1;
    tick();
    checks++;
    if (INSTRUCTION !== 16'hA55A) begin failures++; $display("FAIL instr_load got=%h exp=a55a", INSTRUCTION); end
    PC_ENX = 1'b0; DIN = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (INSTRUCTION !== 16'hA55A) begin failures++; $display("FAIL instr_hold[%0d] got=%h exp=a55a", i, INSTRUCTION); end
    end
  endtask
  task automatic test_sequences();
    for (int c = 0; c < 8; c++) begin
      for (int v = 0; v < 3; v++) begin
        REG_SEQX = 3'(c); BYTEX = (v != 0); A0 = (v == 2);
        for (int k = 0; k < 4; k++) begin
          tick();
          checks++;
          if (obs() !== exp_vec(ph, REG_SEQX)) begin
            failures++; $display("FAIL seq%0d_v%0d_ph%0d got=%b exp=%b", c, v, ph, obs(), exp_vec(ph, REG_SEQX));
          end
`ifdef REG_BYTE_LANE_EN
          checks++;
          if (REGA_WBE !== exp_wbe(ph, REG_SEQX, BYTEX, A0)) begin
            failures++; $display("FAIL wbe_seq%0d_v%0d_ph%0d got=%b exp=%b", c, v, ph, REGA_WBE, exp_wbe(ph, REG_SEQX, BYTEX, A0));
          end
`endif
        end
      end
    end
  endtask
  task automatic test_reset_mid_decode();
    RESET = 1'b0; REG_SEQX = 3'd3;
    for (int i = 0; i < 8 && ph != 2; i++) tick();
    checks++;
    if (!DECODE) begin failures++; $display("FAIL mid_wait_decode got=%b exp=1", DECODE); end
    RESET = 1'b1;
    tick();
    checks++;
    if (obs() !== 8'h00) begin failures++; $display("FAIL mid_reset got=%b exp=%b", obs(), 8'h00); end
    RESET = 1'b0;
    tick();
    checks++;
    if (obs() !== 8'b1000_0000) begin failures++; $display("FAIL mid_restart got=%b exp=%b", obs(), 8'b1000_0000); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RESET = ($urandom_range(0, 40) == 0);
      DIN = 16'($urandom); PC_ENX = 1'($urandom);
      BYTEX = 1'($urandom); A0 = 1'($urandom);
      tick();
      REG_SEQX = 3'($urandom);
      #1;
      checks++;
      if (obs() !== exp_vec(ph, REG_SEQX) || INSTRUCTION !== m_instr) begin
        failures++;
        $display("FAIL random[%0d] got=%b/%h exp=%b/%h", i, obs(), INSTRUCTION, exp_vec(ph, REG_SEQX), m_instr);
      end
`ifdef REG_BYTE_LANE_EN
      checks++;
      if (REGA_WBE !== exp_wbe(ph, REG_SEQX, BYTEX, A0)) begin
        failures++; $display("FAIL random_wbe[%0d] got=%b exp=%b", i, REGA_WBE, exp_wbe(ph, REG_SEQX, BYTEX, A0));
      end
`endif
    end
  endtask
  initial begin
    test_reset();
    test_phase_ring();
    test_instruction();
    test_sequences();
    test_reset_mid_decode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
